// File: rtl/seg7_scan_driver.sv
// Purpose : time-multiplexed common-anode 7-segment scanner; one digit per scan tick, frame-coherent digit snapshot.
// Latency : outputs are registered one cycle after the index/shadow update at the scan tick.
// Backpress: none; en=0 blanks the display and freezes the prescaler and index in place.
//
// Ports:
//   clk, rst    - system clock (rising edge), synchronous active-high reset
//   en          - 1 = scan, 0 = display dark with prescaler/index frozen
//   data_in     - packed nibbles, digit k = data_in[4k+3:4k], digit 0 rightmost
//   dp_in       - per-digit decimal point request (1 = lit)
//   blank_in    - per-digit force-dark
//   lz_en       - suppress leading zeros (digit 0 is never suppressed)
//   seg_out     - active-low {dp,g,f,e,d,c,b,a}
//   an_out      - active-low anode select, one-hot-low or all ones
//   frame_done  - one-cycle pulse on the first output cycle of digit 0
module seg7_scan_driver #(
  parameter int DIGITS   = 8,
  parameter int CLK_DIV  = 100000,
  parameter int HEX_MODE = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [4*DIGITS-1:0] data_in,
  input  logic [DIGITS-1:0]   dp_in,
  input  logic [DIGITS-1:0]   blank_in,
  input  logic                lz_en,
  output logic [7:0]          seg_out,
  output logic [DIGITS-1:0]   an_out,
  output logic                frame_done
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CW-1:0]     COUNT_MAX = CW'(CLK_DIV - 1);
  localparam logic [IW-1:0]     IDX_MAX   = IW'(DIGITS - 1);
  localparam logic [DIGITS-1:0] AN_ONE    = DIGITS'(1);
  localparam logic [6:0]        DASH      = 7'b0111111;

  // Scan state
  logic [CW-1:0] count;
  logic [IW-1:0] idx;
  logic          tick;
  logic          wrap;
  logic [IW-1:0] idx_next;
  logic          new_frame;

  // Frame snapshot: every decode below reads these, never the live inputs
  logic [4*DIGITS-1:0] shadow_data;
  logic [DIGITS-1:0]   shadow_dp;
  logic [DIGITS-1:0]   shadow_blank;
  logic                shadow_lz;

  // Decode of the current slot
  logic [DIGITS-1:0] suppress;
  logic              zero_run;
  logic [3:0]        cur_nib;
  logic              cur_dp;
  logic              cur_dark;
  logic [6:0]        cur_glyph;

  // Active-low {g..a} glyph for one nibble
  function automatic logic [6:0] glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0:    g = 7'b1000000;
      4'h1:    g = 7'b1111001;
      4'h2:    g = 7'b0100100;
      4'h3:    g = 7'b0110000;
      4'h4:    g = 7'b0011001;
      4'h5:    g = 7'b0010010;
      4'h6:    g = 7'b0000010;
      4'h7:    g = 7'b1111000;
      4'h8:    g = 7'b0000000;
      4'h9:    g = 7'b0010000;
      4'hA:    g = (HEX_MODE != 0) ? 7'b0001000 : DASH;
      4'hB:    g = (HEX_MODE != 0) ? 7'b0000011 : DASH;
      4'hC:    g = (HEX_MODE != 0) ? 7'b1000110 : DASH;
      4'hD:    g = (HEX_MODE != 0) ? 7'b0100001 : DASH;
      4'hE:    g = (HEX_MODE != 0) ? 7'b0000110 : DASH;
      default: g = (HEX_MODE != 0) ? 7'b0001110 : DASH;
    endcase
    return g;
  endfunction

  assign tick     = en && (count == COUNT_MAX);
  assign wrap     = (idx == IDX_MAX);
  assign idx_next = wrap ? '0 : idx + 1'b1;

  // Leading-zero mask: walk from the most significant digit down, keeping a
  // running "everything above and including here is zero" flag. Digit 0 is
  // left out of the walk so it always shows something.
  always_comb begin
    suppress = '0;
    zero_run = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      zero_run    = zero_run && (shadow_data[4*k +: 4] == 4'd0);
      suppress[k] = shadow_lz && zero_run;
    end
  end

  always_comb begin
    cur_nib   = shadow_data[{idx, 2'b00} +: 4];
    cur_dp    = shadow_dp[idx];
    cur_dark  = !en || shadow_blank[idx] || suppress[idx];
    cur_glyph = glyph(cur_nib);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count        <= '0;
      idx          <= IDX_MAX;
      new_frame    <= 1'b0;
      shadow_data  <= '0;
      shadow_dp    <= '0;
      shadow_blank <= '1;
      shadow_lz    <= 1'b0;
      seg_out      <= 8'hFF;
      an_out       <= '1;
      frame_done   <= 1'b0;
    end else begin
      // Prescaler only moves while enabled, so a paused digit keeps its
      // remaining on-time.
      if (en) begin
        count <= tick ? '0 : count + 1'b1;
      end

      if (tick) begin
        idx <= idx_next;
        // Wrapping back to digit 0 starts a new frame: capture the inputs
        // present in this very cycle.
        if (wrap) begin
          shadow_data  <= data_in;
          shadow_dp    <= dp_in;
          shadow_blank <= blank_in;
          shadow_lz    <= lz_en;
        end
      end

      // Marks the cycle after the wrap so frame_done lines up with the
      // first registered output of digit 0.
      new_frame  <= tick && wrap;
      frame_done <= new_frame;

      if (cur_dark) begin
        seg_out <= 8'hFF;
        an_out  <= '1;
      end else begin
        seg_out <= {~cur_dp, cur_glyph};
        an_out  <= ~(AN_ONE << idx);
      end
    end
  end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Time-multiplexed driver for a common-anode, active-low 7-segment display bank of DIGITS digits, generalising the single-digit BCD-to-segment decoder. It scans one digit per scan tick and snapshots the packed digit bus once per frame, so a frame never mixes old and new values. It adds optional hex glyphs, per-digit decimal points, per-digit blanking and leading-zero suppression. It sits between the controller's display-value logic and the board's segment/anode pins.

## Interface
- DIGITS, 8, number of digits scanned (1–16)
- CLK_DIV, 100000, clock cycles per scan tick (≥1)
- HEX_MODE, 0, 0: nibbles 10–15 show dash; 1: show A b C d E F
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  1 = scan, 0 = display dark, prescaler and index frozen
- data_in  in  4*DIGITS  packed nibbles, digit k = data_in[4k+3:4k], digit 0 rightmost
- dp_in  in  DIGITS  decimal point request per digit, 1 = lit
- blank_in  in  DIGITS  1 = force digit dark
- lz_en  in  1  1 = suppress leading zeros
- seg_out  out  8  active low {dp,g,f,e,d,c,b,a}
- an_out  out  DIGITS  active-low anode select, one-hot-low or all ones
- frame_done  out  1  one-cycle pulse when digit 0 of a new frame is driven

## Operation
- Prescaler counts 0..CLK_DIV-1 while en=1. tick = en && (count==CLK_DIV-1); count wraps to 0 on tick. CLK_DIV=1 → tick every enabled cycle.
- Index idx advances on tick: DIGITS-1 → 0, else +1.
- Snapshot: on a tick where the next idx is 0, shadow registers load data_in, dp_in, blank_in and lz_en. All decode uses shadow values only.
- Glyph for 7-bit field {g..a}, active low: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
- Nibbles 10–15 with HEX_MODE=0: dash 0111111. With HEX_MODE=1: A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- seg_out[7] = ~dp of the current digit.
- Leading-zero blank: with shadow lz_en=1, digit k≥1 is suppressed when nibbles k..DIGITS-1 are all 0. Digit 0 is never suppressed.
- A digit is dark if shadow blank is set, or it is suppressed, or en=0.
- Dark slot: an_out = all ones and seg_out = 8'hFF, including the dp.
- Lit slot: an_out has only bit idx low; seg_out = {~dp, glyph}.

## Timing
- Reset values: count=0, idx=DIGITS-1, shadow data=0, shadow blank=all ones, seg_out=8'hFF, an_out=all ones, frame_done=0.
- The first tick after reset wraps idx to 0 and takes the first snapshot. The display is dark until then.
- Output pipeline: idx and shadow update on the tick edge. seg_out, an_out and frame_done are registered from them on the following edge, giving 1 cycle of latency after the index change.
- frame_done is high for exactly one cycle, coincident with the first output cycle of digit 0.
- Each digit is driven for CLK_DIV cycles. Frame period = DIGITS*CLK_DIV cycles.
- Input changes mid-frame have no visible effect until the next frame_done.
- en falling: outputs go dark on the next edge; count and idx hold.
- en rising: scanning resumes from the held count and idx; no new snapshot until the next wrap.
- rst mid-frame: all state returns to reset values on that edge, overriding en and tick. Reset has priority over every other event.
- Simultaneous tick and input change: the snapshot captures the values present in the tick cycle.

## Test plan
- Reset: assert rst 3 cycles with random inputs → seg_out=8'hFF, an_out all ones, frame_done=0 throughout and until the first tick.
- Decimal scan (DIGITS=4, CLK_DIV=4, data_in=16'h1234, dp_in=4'b0010, en=1) → repeating sequence, 4 cycles each:
  - an=1110, seg=10011001
  - an=1101, seg=00110000
  - an=1011, seg=10100100
  - an=0111, seg=11111001
  - frame_done pulses every 16 cycles.
- Glyph modes: data_in nibble 0 = 4'hA → seg=10111111 with HEX_MODE=0 and seg=10001000 with HEX_MODE=1. Repeat with 4'hF → 10111111 vs 10001110.
- Leading zeros (lz_en=1): data_in=16'h0050 → digits 3,2 dark (an all ones, seg FF), digit 1 seg=10010010, digit 0 seg=11000000. data_in=0 → only digit 0 lit, showing 11000000.
- Snapshot integrity: change data_in from 16'h1111 to 16'h2222 while idx=1 → digits 1..3 of the current frame still show 11111001; 2 appears only after the next frame_done.
- Enable and mid-frame reset:
  - Drop en for 10 cycles → dark; resumes at the same digit with the remaining count.
  - Pulse rst at idx=2 → dark, then the first tick restarts at digit 0 with a fresh snapshot.
